icache_dm: RTL and testbench

Direct-mapped, read-only instruction cache sitting between the IF stage and the memory read port. Accepts one fetch address per request, returns the 32-bit instruction on hit in one cycle, and on miss refills a full line from memory. Produces `ICache_valid` and `ICache_ready`, which the pipeline control turns into stall and flush: stall/flush while `ICache_valid & ~ICache_ready`.

---
 rtl/icache_pkg.sv | 29 ++
 rtl/icache_line_array.sv | 62 ++++++
 rtl/icache_dm.sv | 149 ++++++++++++++
 tb/tb_icache_dm.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM state encoding,
// default geometry and address-slicing helpers.
package icache_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOOKUP = 3'd1;
    localparam logic [2:0] ST_MISS   = 3'd2;
    localparam logic [2:0] ST_REFILL = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    localparam int INDEX_W_DEF  = 4;
    localparam int OFFSET_W_DEF = 4;
    localparam int WORDS        = 1 << (OFFSET_W_DEF - 2);
    localparam int TAG_W        = 32 - INDEX_W_DEF - OFFSET_W_DEF;

    function automatic int words_of(input int offset_w);
        return 1 << (offset_w - 2);
    endfunction

    function automatic int tag_w_of(input int index_w, input int offset_w);
        return 32 - index_w - offset_w;
    endfunction

    // Clears the byte-offset field, giving the address of the first word of the line.
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int offset_w);
        return addr & ~((32'd1 << offset_w) - 32'd1);
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the instruction cache: combinational read by index,
// one-word refill write port, tag write that validates the line, global invalidate.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           inv,
    input  logic [INDEX_W-1:0]             rd_index,
    input  logic [OFFSET_W-3:0]            rd_word,
    output logic                           rd_valid,
    output logic [31-INDEX_W-OFFSET_W:0]   rd_tag,
    output logic [31:0]                    rd_data,
    input  logic                           wr_en,
    input  logic [INDEX_W-1:0]             wr_index,
    input  logic [OFFSET_W-3:0]            wr_word,
    input  logic [31:0]                    wr_data,
    input  logic                           tag_wr,
    input  logic [31-INDEX_W-OFFSET_W:0]   wr_tag
);

    localparam int LINES   = 1 << INDEX_W;
    localparam int WORDS_L = words_of(OFFSET_W);

    logic [LINES-1:0]                 valid;
    logic [31-INDEX_W-OFFSET_W:0]     tags [LINES];
    logic [31:0]                      data [LINES][WORDS_L];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index][rd_word];

    // The tag write follows the clear so a refill finishing alongside an invalidate keeps its line.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (inv) begin
                valid <= '0;
            end
            if (tag_wr) begin
                valid[wr_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tag_wr) begin
            tags[wr_index] <= wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data[wr_index][wr_word] <= wr_data;
        end
    end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache between IF and the memory read port.
// Optional ICACHE_PERF_CNT_EN adds hit_cnt/miss_cnt lookup counters.
module icache_dm
    import icache_pkg::*;
#(
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_valid,
    input  logic [31:0] pc,
    input  logic        cache_inv,
    output logic        ICache_valid,
    output logic        ICache_ready,
    output logic [31:0] inst,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int WORD_W  = OFFSET_W - 2;
    localparam int WORDS_L = words_of(OFFSET_W);
    localparam int TAG_WL  = tag_w_of(INDEX_W, OFFSET_W);

    logic [2:0]         state;
    logic [2:0]         state_nx;
    logic [31:0]        req_pc;
    logic [WORD_W-1:0]  beat_cnt;
    logic [31:0]        rbuf [WORDS_L];

    logic [INDEX_W-1:0] req_index;
    logic [TAG_WL-1:0]  req_tag;
    logic [WORD_W-1:0]  req_word;
    logic               line_valid;
    logic [TAG_WL-1:0]  line_tag;
    logic [31:0]        line_word;
    logic               hit;
    logic               accept;
    logic               beat_wr;
    logic               last_wr;
    logic               unused_pc_lsb;

    assign req_index     = req_pc[OFFSET_W +: INDEX_W];
    assign req_tag       = req_pc[31 -: TAG_WL];
    assign req_word      = req_pc[2 +: WORD_W];
    assign unused_pc_lsb = ^req_pc[1:0];

    icache_line_array #(
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W)
    ) u_lines (
        .clk      (clk),
        .rst      (rst),
        .inv      (cache_inv),
        .rd_index (req_index),
        .rd_word  (req_word),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_word),
        .wr_en    (beat_wr),
        .wr_index (req_index),
        .wr_word  (beat_cnt),
        .wr_data  (ret_data),
        .tag_wr   (last_wr),
        .wr_tag   (req_tag)
    );

    // Lookup reads the valid bits before any same-cycle invalidate lands.
    assign hit     = (state == ST_LOOKUP) && line_valid && (line_tag == req_tag);
    assign accept  = pc_valid && ((state == ST_IDLE) || hit || (state == ST_RESP));
    assign beat_wr = (state == ST_REFILL) && ret_valid;
    assign last_wr = beat_wr && ret_last;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (pc_valid) state_nx = ST_LOOKUP;
            ST_LOOKUP: begin
                if (hit) state_nx = pc_valid ? ST_LOOKUP : ST_IDLE;
                else     state_nx = ST_MISS;
            end
            ST_MISS:   if (rd_rdy) state_nx = ST_REFILL;
            ST_REFILL: if (last_wr) state_nx = ST_RESP;
            ST_RESP:   state_nx = pc_valid ? ST_LOOKUP : ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            req_pc   <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                req_pc <= pc;
            end
            // Restart at word 0 on the last beat so a short burst cannot skew the next refill.
            if (last_wr) begin
                beat_cnt <= '0;
            end else if (beat_wr) begin
                beat_cnt <= beat_cnt + WORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat_wr) begin
            rbuf[beat_cnt] <= ret_data;
        end
    end

    always_comb begin
        inst = '0;
        if (hit) begin
            inst = line_word;
        end else if (state == ST_RESP) begin
            inst = rbuf[req_word];
        end
    end

    assign ICache_valid = (state != ST_IDLE);
    assign ICache_ready = hit || (state == ST_RESP);
    assign rd_req       = (state == ST_MISS);
    assign rd_addr      = rd_req ? line_base(req_pc, OFFSET_W) : 32'd0;

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == ST_LOOKUP) begin
            if (hit) hit_cnt  <= hit_cnt + 32'd1;
            else     miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed vector table, hand-written corner
// sequences (invalidate during lookup, reset mid-refill) and random fetches vs a set model.
module tb_icache_dm;
    import icache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_valid;
    logic [31:0] pc;
    logic        cache_inv;
    logic        ICache_valid;
    logic        ICache_ready;
    logic [31:0] inst;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_dm #(.INDEX_W(4), .OFFSET_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_valid     (pc_valid),
        .pc           (pc),
        .cache_inv    (cache_inv),
        .ICache_valid (ICache_valid),
        .ICache_ready (ICache_ready),
        .inst         (inst),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_rdy       (rd_rdy),
        .ret_valid    (ret_valid),
        .ret_last     (ret_last),
        .ret_data     (ret_data)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the cache is transparent, so data always equals backing memory;
    // only hit/miss depends on which tag each set currently holds.
    bit          m_valid [16];
    logic [23:0] m_tag   [16];
    int          m_hits   = 0;
    int          m_misses = 0;

    typedef struct {
        logic [31:0] addr;
        int          rdy_delay;
        bit          idle_after;
        bit          exp_hit;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs[$];

    always @(posedge clk) begin
        if (!rst && ret_valid && ret_last && dut.state == ST_REFILL)
            assert (dut.beat_cnt == 2'(WORDS - 1)) else $error("ret_last on wrong beat");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h1C00000) return 32'hA0 + 32'(a[3:2]);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_fetch(input logic [31:0] a, output bit hit);
        hit = m_valid[a[7:4]] && (m_tag[a[7:4]] == a[31:8]);
        if (hit) m_hits++;
        else     m_misses++;
        m_valid[a[7:4]] = 1'b1;
        m_tag[a[7:4]]   = a[31:8];
    endtask

    // Called at a negedge where the cache is IDLE or presenting a result; returns at the
    // negedge of the cycle in which ICache_ready is high for this address.
    task automatic fetch_core(input logic [31:0] a, input int rdy_delay, input bit gaps,
                              output bit saw_req, output int stall, output int gaps_n,
                              output logic [31:0] data);
        int  waited;
        int  beats;
        int  cyc;
        bit  granted;
        bit  done;
        saw_req = 1'b0; stall = 0; gaps_n = 0; data = '0;
        waited = 0; beats = 0; cyc = 0; granted = 1'b0; done = 1'b0;
        pc = a; pc_valid = 1'b1;
        @(posedge clk);
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0;
            if (ICache_ready) begin
                data = inst;
                done = 1'b1;
            end else begin
                stall++;
                if (rd_req) begin
                    saw_req = 1'b1;
                    chk("rd_addr", rd_addr, a & ~32'hF);
                    if (waited >= rdy_delay) begin
                        rd_rdy  = 1'b1;
                        granted = 1'b1;
                    end else begin
                        waited++;
                    end
                end else if (granted && beats < 4) begin
                    if (gaps && $urandom_range(0, 3) == 0) begin
                        gaps_n++;
                    end else begin
                        ret_valid = 1'b1;
                        ret_data  = mem_word((a & ~32'hF) + 32'(beats * 4));
                        ret_last  = (beats == 3);
                        beats++;
                    end
                end
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL fetch_timeout: addr %h got no ICache_ready within %0d cycles", a, cyc);
        end
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] a, input int rdy_delay,
                            input bit gaps, input bit exp_hit, input logic [31:0] exp_inst);
        bit          saw_req;
        int          stall;
        int          gaps_n;
        logic [31:0] data;
        bit          mhit;
        fetch_core(a, rdy_delay, gaps, saw_req, stall, gaps_n, data);
        model_fetch(a, mhit);
        chk({tag, "_miss"}, 32'(saw_req), 32'(!exp_hit));
        chk({tag, "_inst"}, data, exp_inst);
        chk({tag, "_lat"}, 32'(stall), exp_hit ? 32'd0 : 32'(6 + rdy_delay + gaps_n));
    endtask

    initial begin
        bit          hit;
        logic [31:0] a;
        int          d;
        int          act;

        rst = 1'b1; pc_valid = 1'b0; pc = '0; cache_inv = 1'b0;
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(ICache_valid), 32'd0);
        chk("rst_ready", 32'(ICache_ready), 32'd0);
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_rd_addr", rd_addr, 32'd0);
        chk("rst_inst", inst, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        vecs.push_back('{32'h1C00_0004, 0, 1'b0, 1'b0, 32'h0000_00A1});
        vecs.push_back('{32'h1C00_0008, 0, 1'b0, 1'b1, 32'h0000_00A2});
        vecs.push_back('{32'h1C00_000C, 0, 1'b1, 1'b1, 32'h0000_00A3});
        vecs.push_back('{32'h1C00_0100, 2, 1'b0, 1'b0, mem_word(32'h1C00_0100)});
        vecs.push_back('{32'h1C00_0104, 0, 1'b1, 1'b1, mem_word(32'h1C00_0104)});
        vecs.push_back('{32'h1C00_0004, 0, 1'b1, 1'b0, 32'h0000_00A1});
        vecs.push_back('{32'h1C00_0230, 5, 1'b0, 1'b0, mem_word(32'h1C00_0230)});
        vecs.push_back('{32'h1C00_0234, 0, 1'b1, 1'b1, mem_word(32'h1C00_0234)});
        vecs.push_back('{32'h1C00_0108, 0, 1'b1, 1'b0, mem_word(32'h1C00_0108)});

        foreach (vecs[i]) begin
            do_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rdy_delay, 1'b0,
                     vecs[i].exp_hit, vecs[i].exp_inst);
            if (vecs[i].idle_after) begin
                pc_valid = 1'b0;
                @(negedge clk);
            end
        end

        // Invalidate coinciding with a lookup: the lookup still sees the old valid bits.
        pc = 32'h1C00_0238; pc_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("inv_lookup_ready", 32'(ICache_ready), 32'd1);
        chk("inv_lookup_inst", inst, mem_word(32'h1C00_0238));
        model_fetch(32'h1C00_0238, hit);
        cache_inv = 1'b1; pc_valid = 1'b0;
        @(negedge clk);
        cache_inv = 1'b0;
        model_clear();
        do_fetch("after_inv", 32'h1C00_0234, 0, 1'b0, 1'b0, mem_word(32'h1C00_0234));
        pc_valid = 1'b0;
        @(negedge clk);

        // Reset arriving with the third refill beat.
        pc = 32'h1C00_0340; pc_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_req", 32'(rd_req), 32'd1);
        rd_rdy = 1'b1;
        @(negedge clk);
        rd_rdy = 1'b0;
        ret_valid = 1'b1; ret_last = 1'b0; ret_data = mem_word(32'h1C00_0340);
        @(negedge clk);
        ret_data = mem_word(32'h1C00_0344);
        @(negedge clk);
        ret_data = mem_word(32'h1C00_0348);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; ret_valid = 1'b0; pc_valid = 1'b0;
        chk("mid_rst_rd_req", 32'(rd_req), 32'd0);
        chk("mid_rst_valid", 32'(ICache_valid), 32'd0);
        chk("mid_rst_ready", 32'(ICache_ready), 32'd0);
        model_clear();
        m_hits = 0; m_misses = 0;
        do_fetch("post_rst", 32'h1C00_0340, 1, 1'b0, 1'b0, mem_word(32'h1C00_0340));
        do_fetch("post_rst_b", 32'h1C00_0104, 0, 1'b0, 1'b0, mem_word(32'h1C00_0104));
        pc_valid = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 250; n++) begin
            a = 32'h1C00_0000 | (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 4)
                | (32'($urandom_range(0, 3)) << 2);
            d = $urandom_range(0, 3);
            hit = m_valid[a[7:4]] && (m_tag[a[7:4]] == a[31:8]);
            do_fetch("rnd", a, d, 1'b1, hit, mem_word(a));
            act = $urandom_range(0, 5);
            if (act == 0) begin
                pc_valid = 1'b0;
                @(negedge clk);
            end else if (act == 1) begin
                pc_valid = 1'b0; cache_inv = 1'b1;
                @(negedge clk);
                cache_inv = 1'b0;
                model_clear();
            end
        end
        pc_valid = 1'b0;
        @(negedge clk);

`ifdef ICACHE_PERF_CNT_EN
        chk("hit_cnt", hit_cnt, 32'(m_hits));
        chk("miss_cnt", miss_cnt, 32'(m_misses));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
